// File: rtl/jt89_pkg.sv
// JT89 PSG control package: shared widths, register-type and channel
// constants, and the 2 dB/step attenuation table.
package jt89_pkg;

    localparam int PERIOD_W = 10;
    localparam int SND_W    = 11;
    localparam int TERM_W   = 9;

    localparam logic TYPE_TONE = 1'b0;
    localparam logic TYPE_VOL  = 1'b1;

    localparam logic [1:0] CH_T0    = 2'd0;
    localparam logic [1:0] CH_T1    = 2'd1;
    localparam logic [1:0] CH_T2    = 2'd2;
    localparam logic [1:0] CH_NOISE = 2'd3;

    // Linear amplitude for each 4-bit attenuation code; code F is mute.
    function automatic logic [7:0] att(input logic [3:0] vol);
        logic [7:0] r;
        case (vol)
            4'h0:    r = 8'd255;
            4'h1:    r = 8'd203;
            4'h2:    r = 8'd161;
            4'h3:    r = 8'd128;
            4'h4:    r = 8'd102;
            4'h5:    r = 8'd81;
            4'h6:    r = 8'd64;
            4'h7:    r = 8'd51;
            4'h8:    r = 8'd40;
            4'h9:    r = 8'd32;
            4'hA:    r = 8'd26;
            4'hB:    r = 8'd20;
            4'hC:    r = 8'd16;
            4'hD:    r = 8'd13;
            4'hE:    r = 8'd10;
            default: r = 8'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jt89_att_lut.sv
// Shared attenuation lookup, one instance time-multiplexed over all slots.
// Ports: i_vol attenuation code in, o_att linear amplitude out.
module jt89_att_lut
    import jt89_pkg::*;
(
    input  logic [3:0] i_vol,
    output logic [7:0] o_att
);

    assign o_att = att(i_vol);

endmodule

// File: rtl/jt89_ctrl.sv
// JT89 register front-end and 4-slot round-robin volume mixer.
// Ports: clk/rst, clk_en (slot advance), wr_n/din (CPU bus), ch_din
// (square levels), period0..2, noise_ctrl, noise_rst, snd/snd_vld.
module jt89_ctrl
    import jt89_pkg::*;
#(
    parameter bit NOISE_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    wr_n,
    input  logic [7:0]              din,
    input  logic [3:0]              ch_din,
    output logic [PERIOD_W-1:0]     period0,
    output logic [PERIOD_W-1:0]     period1,
    output logic [PERIOD_W-1:0]     period2,
    output logic [2:0]              noise_ctrl,
    output logic                    noise_rst,
    output logic signed [SND_W-1:0] snd,
    output logic                    snd_vld
);

    logic                    r_wr_n_q;
    logic [1:0]              r_lch;
    logic                    r_ltype;
    logic [3:0]              r_vol [4];
    logic [PERIOD_W-1:0]     r_period0;
    logic [PERIOD_W-1:0]     r_period1;
    logic [PERIOD_W-1:0]     r_period2;
    logic [2:0]              r_noise;
    logic                    r_nrst;
    logic [1:0]              r_slot;
    logic signed [SND_W-1:0] r_acc;
    logic signed [SND_W-1:0] r_snd;
    logic                    r_snd_vld;

    logic                     w_wr;
    logic                     w_latch;
    logic [1:0]               w_ch;
    logic                     w_type;
    logic [7:0]               w_att;
    logic signed [TERM_W-1:0] w_mag;
    logic signed [TERM_W-1:0] w_term;
    logic signed [SND_W-1:0]  w_term_x;
    logic signed [SND_W-1:0]  w_sum;

    // Falling edge of wr_n: a held-low strobe yields a single write.
    assign w_wr    = ~wr_n & r_wr_n_q;
    assign w_latch = din[7];
    // Latch bytes address themselves; data bytes reuse the latched target.
    assign w_ch    = w_latch ? din[6:5] : r_lch;
    assign w_type  = w_latch ? din[4]   : r_ltype;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_n_q  <= 1'b1;
            r_lch     <= CH_T0;
            r_ltype   <= TYPE_TONE;
            for (int i = 0; i < 4; i++) r_vol[i] <= 4'hF;
            r_period0 <= '0;
            r_period1 <= '0;
            r_period2 <= '0;
            r_noise   <= '0;
            r_nrst    <= 1'b0;
        end else begin
            r_wr_n_q <= wr_n;
            r_nrst   <= 1'b0;
            if (w_wr) begin
                if (w_latch) begin
                    r_lch   <= din[6:5];
                    r_ltype <= din[4];
                end
                if (w_type == TYPE_VOL) begin
                    r_vol[w_ch] <= din[3:0];
                end else if (w_ch == CH_NOISE) begin
                    r_noise <= din[2:0];
                    r_nrst  <= 1'b1;
                end else if (w_latch) begin
                    case (w_ch)
                        CH_T0:   r_period0[3:0] <= din[3:0];
                        CH_T1:   r_period1[3:0] <= din[3:0];
                        default: r_period2[3:0] <= din[3:0];
                    endcase
                end else begin
                    case (w_ch)
                        CH_T0:   r_period0[9:4] <= din[5:0];
                        CH_T1:   r_period1[9:4] <= din[5:0];
                        default: r_period2[9:4] <= din[5:0];
                    endcase
                end
            end
        end
    end

    jt89_att_lut u_lut (
        .i_vol (r_vol[r_slot]),
        .o_att (w_att)
    );

    assign w_mag = {1'b0, w_att};

    always_comb begin
        w_term = '0;
        if (!(r_slot == CH_NOISE && !NOISE_EN)) begin
            w_term = ch_din[r_slot] ? w_mag : -w_mag;
        end
    end

    assign w_term_x = {{(SND_W-TERM_W){w_term[TERM_W-1]}}, w_term};
    assign w_sum    = r_acc + w_term_x;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot    <= CH_T0;
            r_acc     <= '0;
            r_snd     <= '0;
            r_snd_vld <= 1'b0;
        end else begin
            r_snd_vld <= 1'b0;
            if (clk_en) begin
                r_slot <= r_slot + 2'd1;
                if (r_slot == CH_NOISE) begin
                    r_snd     <= w_sum;
                    r_acc     <= '0;
                    r_snd_vld <= 1'b1;
                end else begin
                    r_acc <= w_sum;
                end
            end
        end
    end

    assign period0    = r_period0;
    assign period1    = r_period1;
    assign period2    = r_period2;
    assign noise_ctrl = r_noise;
    assign noise_rst  = r_nrst;
    assign snd        = r_snd;
    assign snd_vld    = r_snd_vld;

endmodule

// File: tb/tb_jt89_ctrl.sv
// Scoreboard bench for jt89_ctrl: one instance with noise mixed in, one
// with the noise slot muted, driven in lock-step.
module tb_jt89_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        wr_n;
    logic [7:0]  din;
    logic [3:0]  ch_din;

    logic [9:0]  p0, p1, p2, bp0, bp1, bp2;
    logic [2:0]  nc, bnc;
    logic        nr, bnr;
    logic signed [10:0] snd, bsnd;
    logic        vld, bvld;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int a;
        int b;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    jt89_ctrl u_dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .wr_n       (wr_n),
        .din        (din),
        .ch_din     (ch_din),
        .period0    (p0),
        .period1    (p1),
        .period2    (p2),
        .noise_ctrl (nc),
        .noise_rst  (nr),
        .snd        (snd),
        .snd_vld    (vld)
    );

    jt89_ctrl #(.NOISE_EN(1'b0)) u_dut_nn (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .wr_n       (wr_n),
        .din        (din),
        .ch_din     (ch_din),
        .period0    (bp0),
        .period1    (bp1),
        .period2    (bp2),
        .noise_ctrl (bnc),
        .noise_rst  (bnr),
        .snd        (bsnd),
        .snd_vld    (bvld)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every snd_vld pops one expected frame.
    always @(negedge clk) begin : mon
        exp_t e;
        if (vld || bvld) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_vld: got snd %0d with no frame expected",
                         snd);
            end else begin
                e = q.pop_front();
                chk("snd", int'(snd), e.a);
                chk("snd_noise_off", int'(bsnd), e.b);
                chk("vld_pair", int'(bvld), int'(vld));
            end
        end
    end

    task automatic wr(input logic [7:0] b, output logic n1, output logic n2);
        din  = b;
        wr_n = 1'b0;
        @(posedge clk);
        #1 n1 = nr;
        wr_n = 1'b1;
        @(posedge clk);
        #1 n2 = nr;
    endtask

    task automatic wrq(input logic [7:0] b);
        logic a, c;
        wr(b, a, c);
    endtask

    task automatic frame(input int ea, input int eb, input logic [3:0] cd);
        exp_t e;
        e.a = ea;
        e.b = eb;
        q.push_back(e);
        ch_din = cd;
        clk_en = 1'b1;
        repeat (4) @(posedge clk);
        #1 clk_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin : wdog
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        logic n1, n2;
        exp_t e;
        rst    = 1'b1;
        clk_en = 1'b0;
        wr_n   = 1'b1;
        din    = 8'h00;
        ch_din = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_snd", int'(snd), 0);
        chk("rst_vld", int'(vld), 0);
        chk("rst_p0", int'(p0), 0);
        chk("rst_nc", int'(nc), 0);
        chk("rst_nr", int'(nr), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // All muted
        frame(0, 0, 4'hF);
        frame(0, 0, 4'hF);

        // ch0 full volume
        wrq(8'h90);
        frame(255, 255, 4'b0001);
        frame(-255, -255, 4'b0000);

        // all channels full volume
        wrq(8'hB0);
        wrq(8'hD0);
        wrq(8'hF0);
        frame(1020, 765, 4'hF);
        frame(-1020, -765, 4'h0);
        frame(0, 255, 4'b0101);

        // mixed attenuations: 203, 81, 26, 10
        wrq(8'h91);
        wrq(8'hB5);
        wrq(8'hDA);
        wrq(8'hFE);
        frame(268, 258, 4'b1011);

        // tone periods
        wrq(8'h8A);
        wrq(8'h3F);
        chk("period0", int'(p0), 10'h3FA);
        wrq(8'hA5);
        wrq(8'h01);
        chk("period1", int'(p1), 10'h015);
        wrq(8'hCF);
        wrq(8'h2A);
        chk("period2", int'(p2), 10'h2AF);
        chk("period0_kept", int'(p0), 10'h3FA);

        // noise control
        wr(8'hE5, n1, n2);
        chk("noise_ctrl_latch", int'(nc), 3'b101);
        chk("noise_rst_hi", int'(n1), 1);
        chk("noise_rst_lo", int'(n2), 0);
        wr(8'h06, n1, n2);
        chk("noise_ctrl_data", int'(nc), 3'b110);
        chk("noise_rst_hi2", int'(n1), 1);
        chk("noise_rst_lo2", int'(n2), 0);
        wr(8'hF0, n1, n2);
        chk("noise_rst_vol", int'(n1), 0);
        wr(8'h07, n1, n2);
        chk("noise_rst_vdata", int'(n1), 0);
        chk("noise_ctrl_kept", int'(nc), 3'b110);

        // held-low strobe is a single write; later din changes ignored
        din  = 8'h93;
        wr_n = 1'b0;
        repeat (5) @(posedge clk);
        #1 din = 8'h97;
        repeat (5) @(posedge clk);
        #1;
        chk("hold_snd", int'(snd), 268);
        wr_n = 1'b1;
        @(posedge clk);
        #1;
        // vols: ch0 3 (128), ch1 81, ch2 26, noise 7 (51)
        frame(-30, 21, 4'b0001);

        // write to vol0 in the very cycle slot 0 reads it
        e.a = -30;
        e.b = 21;
        q.push_back(e);
        ch_din = 4'b0001;
        clk_en = 1'b1;
        din    = 8'h9F;
        wr_n   = 1'b0;
        @(posedge clk);
        #1 wr_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 clk_en = 1'b0;
        @(posedge clk);
        #1;
        frame(-158, -107, 4'b0001);

        // reset mid-frame (slot 2, acc nonzero)
        ch_din = 4'b0001;
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_snd", int'(snd), 0);
        chk("midrst_vld", int'(vld), 0);
        chk("midrst_snd_nn", int'(bsnd), 0);
        clk_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_p0", int'(p0), 0);
        chk("midrst_nc", int'(nc), 0);
        @(posedge clk);
        #1;
        frame(0, 0, 4'hF);
        wrq(8'h90);
        frame(255, 255, 4'b0001);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
